// File: rtl/alu_exec_stage.sv
// Execute stage driving the register-file write port: single-cycle logic ops, iterative shifts,
// and an iterative shift-add multiply that is only built when ALU_MUL_EN is defined.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    rd,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             ovf
);
  // state | meaning
  // IDLE  | ready to accept an op
  // SHIFT | shift accumulator one bit per cycle until count expires
  // MUL   | shift-add multiply, one multiplier bit per cycle
  // WB    | one-cycle write strobe to the register file

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
`ifdef ALU_MUL_EN
    , MUL = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [3:0]       opReg;
  logic [AW-1:0]    rdReg;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum, diff, aluRes, shiftNext;
  logic             aluOvf, isSingle, isShift;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, mulNext;
  logic             isMul;
  assign isMul   = (op == OP_MUL);
  assign mulNext = mplier[0] ? acc + mcand : acc;
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign sum      = a + b;
  assign diff     = a - b;
  assign isShift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  // A zero shift amount needs no iteration and completes like a logic op.
  assign isSingle = (op <= OP_NOT) || (op == OP_SLT) || (op == OP_PASS) ||
                    (isShift && (b[SW-1:0] == '0));

  always_comb begin
    aluRes = '0;
    aluOvf = 1'b0;
    case (op)
      OP_ADD: begin
        aluRes = sum;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diff;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  aluRes = a & b;
      OP_OR:   aluRes = a | b;
      OP_XOR:  aluRes = a ^ b;
      OP_NOT:  aluRes = ~a;
      OP_SLL, OP_SRL, OP_SRA: aluRes = a;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: aluRes = b;
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    shiftNext = {acc[WIDTH-1], acc[WIDTH-1:1]};
    if (opReg == OP_SLL)      shiftNext = {acc[WIDTH-2:0], 1'b0};
    else if (opReg == OP_SRL) shiftNext = {1'b0, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opReg   <= '0;
      rdReg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ovf     <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opReg <= op;
          rdReg <= rd;
          acc   <= a;
          cnt   <= CW'(b[SW-1:0]);
          if (isSingle) begin
            state   <= WB;
            wr_en   <= 1'b1;
            wr_addr <= rd;
            wr_data <= aluRes;
            ovf     <= aluOvf;
          end else if (isShift) begin
            state <= SHIFT;
`ifdef ALU_MUL_EN
          end else if (isMul) begin
            state  <= MUL;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            mcand  <= a;
            mplier <= b;
`endif
          end
        end
        SHIFT: begin
          acc <= shiftNext;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= WB;
            wr_en   <= 1'b1;
            wr_addr <= rdReg;
            wr_data <= shiftNext;
            ovf     <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          acc    <= mulNext;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= WB;
            wr_en   <= 1'b1;
            wr_addr <= rdReg;
            wr_data <= mulNext;
            ovf     <= 1'b0;
          end
        end
`endif
        WB: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: issued ops push expected writebacks, a negedge monitor
// pops and compares them, and also checks in_ready, strobe spacing and output hold.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ovf;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_exec_stage #(.WIDTH(16), .AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .rd(rd), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [15:0] data;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon;
  int          checks = 0;
  int          failures = 0;
  int          busyUntil = -1;
  logic [4:0]  lastAddr = '0;
  logic [15:0] lastData = '0;
  logic        lastOvf = 1'b0;
  logic        prevWrEn = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference behaviour from the opcode definitions using plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                output bit wb, output logic [15:0] res, output bit v, output int lat);
    int sa, sb, r, k;
    sa = sx(x); sb = sx(y); k = int'(y[3:0]);
    wb = 1'b1; v = 1'b0; lat = 0; res = '0; r = 0;
    case (o)
      4'd0: begin r = sa + sb; v = (r > 32767) || (r < -32768); res = 16'(r); end
      4'd1: begin r = sa - sb; v = (r > 32767) || (r < -32768); res = 16'(r); end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = x ^ y;
      4'd5: res = ~x;
      4'd6: begin res = 16'(int'(x) << k); lat = k; end
      4'd7: begin res = 16'(int'(x) >> k); lat = k; end
      4'd8: begin res = 16'(sa >>> k); lat = k; end
      4'd9: res = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: begin
        if (MUL_EN) begin res = 16'(longint'(x) * longint'(y)); lat = 16; end
        else wb = 1'b0;
      end
      4'd11: res = y;
      default: wb = 1'b0;
    endcase
  endfunction

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0] r);
    bit wb, v, got;
    logic [15:0] res;
    int lat;
    exp_t e;
    got = 1'b0;
    op = o; a = x; b = y; rd = r; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_ready_timeout: in_ready stayed 0, required 1 (cycle %0d)", cyc);
      in_valid = 1'b0;
      return;
    end
    #1;
    model(o, x, y, wb, res, v, lat);
    if (wb) begin
      e.rd = r; e.data = res; e.ovf = v; e.due = cyc + 1 + lat;
      sbq.push_back(e);
      busyUntil = cyc + 1 + lat;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); rd = 5'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst && sbq.size() > 0 && cyc > sbq[0].due) begin
      checks++; failures++;
      $display("FAIL wb_missing: no wr_en for rd=%0d by cycle %0d (due %0d)", sbq[0].rd, cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (!rst) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, (cyc > busyUntil)});
      if (wr_en) begin
        check("wr_en_gap", {31'b0, prevWrEn}, 32'd0);
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: wr_en=1 addr=%0d data=0x%0h, required no write (cycle %0d)",
                   wr_addr, wr_data, cyc);
        end else begin
          mon = sbq.pop_front();
          check("wr_addr", {27'b0, wr_addr}, {27'b0, mon.rd});
          check("wr_data", {16'b0, wr_data}, {16'b0, mon.data});
          check("ovf", {31'b0, ovf}, {31'b0, mon.ovf});
          check("wb_cycle", cyc, mon.due);
          lastAddr = mon.rd; lastData = mon.data; lastOvf = mon.ovf;
        end
      end else begin
        check("hold_addr", {27'b0, wr_addr}, {27'b0, lastAddr});
        check("hold_data", {16'b0, wr_data}, {16'b0, lastData});
        check("hold_ovf", {31'b0, ovf}, {31'b0, lastOvf});
      end
    end
    prevWrEn = wr_en;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'b0, wr_data}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    idle(1);

    issue(4'd0, 16'h7FFF, 16'h0001, 5'd3);
    issue(4'd1, 16'h0005, 16'h0007, 5'd4);
    idle(1);
    issue(4'd6, 16'h0001, 16'h0004, 5'd5);
    issue(4'd8, 16'h8000, 16'h000F, 5'd6);
    issue(4'd10, 16'h0003, 16'h0005, 5'd7);
    issue(4'd10, 16'h1234, 16'h0100, 5'd8);
    issue(4'd9, 16'hFFFF, 16'h0001, 5'd9);
    issue(4'd13, 16'h1111, 16'h2222, 5'd10);
    idle(3);
    issue(4'd0, 16'h8000, 16'h8000, 5'd0);
    issue(4'd1, 16'h8000, 16'h0001, 5'd1);
    issue(4'd7, 16'hABCD, 16'h0010, 5'd2);
    issue(4'd11, 16'h0000, 16'hBEEF, 5'd31);
    issue(4'd0, 16'h1234, 16'h4321, 5'd11);
    issue(4'd4, 16'hF0F0, 16'h0FF0, 5'd12);

    for (int i = 0; i < 250; i++) begin
      logic [15:0] y;
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(0, 15));
      issue(4'($urandom_range(0, 15)), 16'($urandom), y, 5'($urandom));
      idle($urandom_range(0, 2));
    end

    if (MUL_EN) issue(4'd10, 16'h0003, 16'h0005, 5'd13);
    else issue(4'd8, 16'h8000, 16'h000F, 5'd13);
    idle(7);
    rst = 1'b1;
    sbq.delete();
    lastAddr = '0; lastData = '0; lastOvf = 1'b0;
    idle(2);
    check("abort_wr_en", {31'b0, wr_en}, 32'd0);
    check("abort_wr_addr", {27'b0, wr_addr}, 32'd0);
    check("abort_wr_data", {16'b0, wr_data}, 32'd0);
    check("abort_ovf", {31'b0, ovf}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    busyUntil = cyc - 1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    idle(20);
    issue(4'd0, 16'h0001, 16'h0002, 5'd14);
    issue(4'd6, 16'h8001, 16'h0001, 5'd15);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1);
    if (sbq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d writebacks outstanding, required 0", sbq.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
